// File: rtl/fixedpt_accum_pkg.sv
// Shared types and width helpers for the fixed-point accumulate stage.
package fixedpt_accum_pkg;

    typedef enum logic {ACCUM, DONE} accum_state_t;

    // Accumulator width that holds a sum of up to len full-range terms.
    function automatic int acc_width(input int data_w, input int len);
        return data_w + $clog2(len + 1);
    endfunction

endpackage

// File: rtl/fixedpt_sat_narrow.sv
// Narrows a wide fixed-point value to the output format by clamping or wrapping.
module fixedpt_sat_narrow #(
    parameter int IN_W     = 36,
    parameter int OUT_W    = 32,
    parameter bit SIGN     = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    function automatic logic [OUT_W-1:0] sat_narrow(input logic signed [IN_W-1:0] x);
        logic [IN_W-OUT_W:0] hi;
        hi = x[IN_W-1:OUT_W-1];
        if (!SATURATE)
            return x[OUT_W-1:0];
        if (SIGN) begin
            // In range only when every bit above the output sign bit matches it.
            if (hi == '0 || hi == '1)
                return x[OUT_W-1:0];
            return x[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
        return (|hi[IN_W-OUT_W:1]) ? {OUT_W{1'b1}} : x[OUT_W-1:0];
    endfunction

    assign dout = signed'(sat_narrow(din));

endmodule

// File: rtl/fixedpt_accumulator.sv
// Val/rdy accumulator summing up to LEN products per vector into one narrowed sum.
module fixedpt_accumulator
    import fixedpt_accum_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LEN      = 8,
    parameter bit SIGN     = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recv_val,
    output logic              recv_rdy,
    input  logic [DATA_W-1:0] recv_msg,
    input  logic              recv_last,
    output logic              send_val,
    input  logic              send_rdy,
    output logic [DATA_W-1:0] send_msg
);

    localparam int ACC_W = acc_width(DATA_W, LEN);
    localparam int CNT_W = ACC_W - DATA_W;

    accum_state_t              state;
    logic signed [ACC_W-1:0]   acc_p1;
    logic        [CNT_W-1:0]   count_p1;
    logic signed [DATA_W-1:0]  msg_p1;

    logic signed [ACC_W-1:0]   term_p0;
    logic signed [ACC_W-1:0]   sum_p0;
    logic signed [DATA_W-1:0]  narrow_p0;
    logic                      end_p0;

    // Stage p0: extend the incoming term and form the running sum.
    always_comb begin
        term_p0 = '0;
        if (SIGN)
            term_p0 = ACC_W'(signed'(recv_msg));
        else
            term_p0 = signed'(ACC_W'(recv_msg));
        sum_p0 = acc_p1 + term_p0;
        end_p0 = recv_last || (count_p1 == CNT_W'(LEN - 1));
    end

    fixedpt_sat_narrow #(
        .IN_W    (ACC_W),
        .OUT_W   (DATA_W),
        .SIGN    (SIGN),
        .SATURATE(SATURATE)
    ) u_narrow (
        .din (sum_p0),
        .dout(narrow_p0)
    );

    // Stage p1: accumulator, term counter, held result and handshake state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCUM;
            acc_p1   <= '0;
            count_p1 <= '0;
            msg_p1   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (recv_val) begin
                        if (end_p0) begin
                            msg_p1   <= narrow_p0;
                            state    <= DONE;
                            acc_p1   <= '0;
                            count_p1 <= '0;
                        end else begin
                            acc_p1   <= sum_p0;
                            count_p1 <= count_p1 + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (send_rdy)
                        state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign recv_rdy = (state == ACCUM);
    assign send_val = (state == DONE);
    assign send_msg = msg_p1;

endmodule

// File: tb/tb_fixedpt_accumulator.sv
// Scoreboard bench: instance 0 is signed/saturating, instance 1 unsigned/wrapping (n=8, len=4).
module tb_fixedpt_accumulator;

    logic       clk;
    logic       reset;
    logic       rv[2];
    logic       rr[2];
    logic [7:0] rm[2];
    logic       rl[2];
    logic       sv[2];
    logic       sr[2];
    logic [7:0] sm[2];

    int nchecks = 0;
    int nerr    = 0;
    int bp_mode[2];
    longint psum[2];
    int pcnt[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        fixedpt_accumulator #(
            .DATA_W  (8),
            .LEN     (4),
            .SIGN    (g == 0),
            .SATURATE(g == 0)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .recv_val (rv[g]),
            .recv_rdy (rr[g]),
            .recv_msg (rm[g]),
            .recv_last(rl[g]),
            .send_val (sv[g]),
            .send_rdy (sr[g]),
            .send_msg (sm[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer sum of the vector, then the output format rule.
    function automatic longint term_value(input int k, input logic [7:0] v);
        longint r;
        if (k == 0) r = longint'($signed(v));
        else        r = longint'({56'd0, v});
        return r;
    endfunction

    function automatic logic [7:0] expect_sum(input int k, input longint s);
        longint r;
        if (k == 0) begin
            r = s;
            if (r > 127)  r = 127;
            if (r < -128) r = -128;
        end else begin
            r = s % 256;
        end
        return r[7:0];
    endfunction

    task automatic push_exp(input int k, input logic [7:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Offer one term; called and returns on a falling edge.
    task automatic put(input int k, input int v, input bit last);
        int guard;
        guard = 0;
        rv[k] = 1'b1;
        rm[k] = 8'(v);
        rl[k] = last;
        while (!rr[k] && guard <= 200) begin
            @(negedge clk);
            guard++;
        end
        if (!rr[k]) begin
            check("recv_rdy_timeout", 0, 1);
        end else begin
            psum[k] += term_value(k, rm[k]);
            pcnt[k]++;
            if (last || pcnt[k] == 4) begin
                push_exp(k, expect_sum(k, psum[k]));
                psum[k] = 0;
                pcnt[k] = 0;
            end
            @(negedge clk);
        end
        rv[k] = 1'b0;
        rl[k] = 1'b0;
    endtask

    // Monitor: chooses send_rdy for the coming edge, then checks any sum that will be accepted.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (bp_mode[k] == 0)      sr[k] = 1'b1;
                else if (bp_mode[k] == 2) sr[k] = 1'b0;
                else                      sr[k] = 1'($urandom % 2);
                if (!reset && sv[k] && sr[k]) begin
                    if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                        check(k == 0 ? "unexpected_sum_s" : "unexpected_sum_u", longint'(sm[k]), -1);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check(k == 0 ? "sum_s" : "sum_u", longint'(sm[k]), longint'(e));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] held;
        int guard;
        for (int k = 0; k < 2; k++) begin
            rv[k] = 1'b0; rm[k] = '0; rl[k] = 1'b0; sr[k] = 1'b1;
            bp_mode[k] = 0; psum[k] = 0; pcnt[k] = 0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_recv_rdy", longint'(rr[k]), 1);
            check("reset_send_val", longint'(sv[k]), 0);
            check("reset_send_msg", longint'(sm[k]), 0);
        end
        reset = 1'b0;
        @(negedge clk);

        // Four terms back to back: ready on each, then the sum appears.
        for (int i = 1; i <= 4; i++) begin
            check("rdy_during_vector", longint'(rr[0]), 1);
            put(0, i, 1'b0);
        end
        check("rdy_after_vector", longint'(rr[0]), 0);
        check("val_after_vector", longint'(sv[0]), 1);
        @(negedge clk);

        // Saturation both ways, and an out-of-range intermediate that recovers.
        put(0, 100, 0); put(0, 100, 0); put(0, 0, 0); put(0, 0, 0);
        put(0, -100, 0); put(0, -100, 0); put(0, 0, 0); put(0, 0, 0);
        put(0, 100, 0); put(0, 100, 0); put(0, -100, 0); put(0, -100, 0);

        // Early last, then a full vector starting from a clean accumulator.
        put(0, 5, 1);
        put(0, 1, 0); put(0, 1, 0); put(0, 1, 0); put(0, 1, 0);
        @(negedge clk);

        // Backpressure: sum held, no term taken while the next one waits.
        bp_mode[0] = 2;
        put(0, 9, 1);
        rv[0] = 1'b1; rm[0] = 8'd3; rl[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_send_val", longint'(sv[0]), 1);
            check("bp_send_msg", longint'(sm[0]), 9);
            check("bp_recv_rdy", longint'(rr[0]), 0);
            @(negedge clk);
        end
        bp_mode[0] = 0;
        guard = 0;
        while (sv[0] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp_release_val", longint'(sv[0]), 0);
        check("bp_release_rdy", longint'(rr[0]), 1);
        put(0, 3, 1);

        // Reset mid-vector discards the partial sum.
        put(0, 7, 0); put(0, 7, 0);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin psum[k] = 0; pcnt[k] = 0; end
        @(negedge clk);
        check("midreset_recv_rdy", longint'(rr[0]), 1);
        check("midreset_send_val", longint'(sv[0]), 0);
        check("midreset_send_msg", longint'(sm[0]), 0);
        reset = 1'b0;
        @(negedge clk);
        put(0, 1, 0); put(0, 1, 0); put(0, 1, 0); put(0, 1, 0);

        // Unsigned wrap instance.
        put(1, 200, 0); put(1, 100, 0); put(1, 0, 0); put(1, 0, 0);
        put(1, 255, 0); put(1, 255, 0); put(1, 255, 0); put(1, 255, 0);
        put(1, 77, 1);

        // Randomized vectors with random gaps, last flags and backpressure.
        for (int k = 0; k < 2; k++) begin
            bp_mode[k] = 1;
            for (int i = 0; i < 150; i++) begin
                if ($urandom % 4 == 0) @(negedge clk);
                held = 8'($urandom);
                if ($urandom % 3 == 0) held = ($urandom % 2 == 0) ? 8'h7F : 8'h80;
                put(k, int'(held), ($urandom % 5) == 0);
            end
            if (pcnt[k] != 0) put(k, 0, 1'b1);
            bp_mode[k] = 0;
        end

        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_q_s", longint'(q0.size()), 0);
        check("drain_q_u", longint'(q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
